// File: rtl/sar_adc_mc.sv
// Multi-channel successive-approximation ADC behavioural model (real-valued inputs).
// Start/busy/valid handshake with optional back-to-back scan of ch_sel..NCH-1.
module sar_adc_mc #(
  parameter int N   = 3,
  parameter int NCH = 4,
  parameter int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  real           VIN [NCH],
  input  real           VSUP,
  input  logic          start,
  input  logic [CW-1:0] ch_sel,
  input  logic          scan,
  output logic          busy,
  output logic          valid,
  output logic [N-1:0]  code,
  output logic [CW-1:0] ch_out,
  output logic          ovr,
  output logic          unr
);

  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, SAMPLE, CONV, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cur_ch_q, cur_ch_d;
  logic          scan_q, scan_d;
  real           vhold_q, vhold_d;
  logic          ovr_r_q, ovr_r_d;
  logic          unr_r_q, unr_r_d;
  logic [N-1:0]  trial_q, trial_d;
  logic [KW-1:0] k_q, k_d;
  logic [N-1:0]  code_q, code_d;
  logic [CW-1:0] ch_out_q, ch_out_d;
  logic          ovr_q, ovr_d;
  logic          unr_q, unr_d;

  real           delta;
  real           full_scale;
  real           vsel;
  logic [N-1:0]  trial_try;

  always_comb begin
    delta      = VSUP / real'(2 ** N);
    full_scale = real'((2 ** N) - 1) * delta;

    vsel = 0.0;
    for (int i = 0; i < NCH; i++) begin
      if (int'(cur_ch_q) == i) vsel = VIN[i];
    end

    trial_try      = trial_q;
    trial_try[k_q] = 1'b1;

    state_d  = state_q;
    cur_ch_d = cur_ch_q;
    scan_d   = scan_q;
    vhold_d  = vhold_q;
    ovr_r_d  = ovr_r_q;
    unr_r_d  = unr_r_q;
    trial_d  = trial_q;
    k_d      = k_q;
    code_d   = code_q;
    ch_out_d = ch_out_q;
    ovr_d    = ovr_q;
    unr_d    = unr_q;

    case (state_q)
      IDLE: begin
        if (start && (int'(ch_sel) < NCH)) begin
          cur_ch_d = ch_sel;
          scan_d   = scan;
          state_d  = SAMPLE;
        end
      end
      SAMPLE: begin
        vhold_d = vsel;
        unr_r_d = (vsel < 0.0);
        ovr_r_d = (vsel > VSUP);
        trial_d = '0;
        k_d     = KW'(N - 1);
        state_d = CONV;
      end
      CONV: begin
        trial_d = (vhold_q >= real'(trial_try) * delta) ? trial_try : trial_q;
        k_d     = k_q - KW'(1);
        // Result registers load on the last bit so they are stable for the whole DONE cycle.
        if (k_q == '0) begin
          if (unr_r_q)                    code_d = '0;
          else if (vhold_q >= full_scale) code_d = '1;
          else                            code_d = trial_d;
          ch_out_d = cur_ch_q;
          ovr_d    = ovr_r_q;
          unr_d    = unr_r_q;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (scan_q && (int'(cur_ch_q) < NCH - 1)) begin
          cur_ch_d = cur_ch_q + CW'(1);
          state_d  = SAMPLE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      cur_ch_q <= '0;
      scan_q   <= 1'b0;
      vhold_q  <= 0.0;
      ovr_r_q  <= 1'b0;
      unr_r_q  <= 1'b0;
      trial_q  <= '0;
      k_q      <= '0;
      code_q   <= '0;
      ch_out_q <= '0;
      ovr_q    <= 1'b0;
      unr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_ch_q <= cur_ch_d;
      scan_q   <= scan_d;
      vhold_q  <= vhold_d;
      ovr_r_q  <= ovr_r_d;
      unr_r_q  <= unr_r_d;
      trial_q  <= trial_d;
      k_q      <= k_d;
      code_q   <= code_d;
      ch_out_q <= ch_out_d;
      ovr_q    <= ovr_d;
      unr_q    <= unr_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign valid  = (state_q == DONE);
  assign code   = code_q;
  assign ch_out = ch_out_q;
  assign ovr    = ovr_q;
  assign unr    = unr_q;

`ifndef SYNTHESIS
  // Ideal flash reference: count of thresholds i*delta that the held value reaches.
  logic [N-1:0] flash_code;

  always_comb begin
    flash_code = '0;
    for (int i = 1; i < (2 ** N); i++) begin
      if (vhold_q >= real'(i) * delta) flash_code = flash_code + N'(1);
    end
  end

  a_valid_after_busy: assert property (@(posedge CLK) valid |-> $past(busy));
  a_flash_match:      assert property (@(posedge CLK) (valid && !ovr && !unr) |-> (code == flash_code));
  a_reset_idle:       assert property (@(posedge CLK) !$past(RST_N) |-> !busy);
`endif

endmodule

// File: tb/tb_sar_adc_mc.sv
// Scoreboard bench for sar_adc_mc: directed conversions push expected results,
// a negedge monitor pops and compares whenever valid is presented.
module tb_sar_adc_mc;

  localparam int N   = 3;
  localparam int NCH = 4;
  localparam int CW  = 3;

  logic          CLK;
  logic          RST_N;
  real           vin [NCH];
  real           vsup;
  logic          start;
  logic [CW-1:0] ch_sel;
  logic          scan;
  logic          busy;
  logic          valid;
  logic [N-1:0]  code;
  logic [CW-1:0] ch_out;
  logic          ovr;
  logic          unr;

  typedef struct {
    int ch;
    int code;
    int ovr;
    int unr;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   valid_count = 0;

  sar_adc_mc #(.N(N), .NCH(NCH), .CW(CW)) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .VIN    (vin),
    .VSUP   (vsup),
    .start  (start),
    .ch_sel (ch_sel),
    .scan   (scan),
    .busy   (busy),
    .valid  (valid),
    .code   (code),
    .ch_out (ch_out),
    .ovr    (ovr),
    .unr    (unr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: every presented result is matched against the oldest expectation.
  always @(negedge CLK) begin
    if (valid) begin
      exp_t e;
      valid_count++;
      if (sb.size() == 0) begin
        checkOutput("unexpected_valid", int'(valid), 0);
      end else begin
        e = sb.pop_front();
        checkOutput("ch_out", int'(ch_out), e.ch);
        checkOutput("code", int'(code), e.code);
        checkOutput("ovr", int'(ovr), e.ovr);
        checkOutput("unr", int'(unr), e.unr);
        checkOutput("latency", cyc, e.cyc);
      end
    end
  end

  task automatic pushExp(input int ch, input int c, input int o, input int u, input int at);
    exp_t e;
    e.ch = ch; e.code = c; e.ovr = o; e.unr = u; e.cyc = at;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input int ch, input bit sc, input bit exp_busy, output int t);
    @(negedge CLK);
    ch_sel = CW'(ch);
    scan   = sc;
    start  = 1'b1;
    t      = cyc + 1;
    @(negedge CLK);
    start  = 1'b0;
    checkOutput("busy_after_start", int'(busy), int'(exp_busy));
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 200 && (busy || sb.size() != 0); i++) @(negedge CLK);
    if (busy || sb.size() != 0) checkOutput("idle_timeout", sb.size() + int'(busy), 0);
    @(negedge CLK);
  endtask

  task automatic convertOne(input int ch, input real v, input int c, input int o, input int u);
    int t;
    vin[ch] = v;
    applyStimulus(ch, 1'b0, 1'b1, t);
    pushExp(ch, c, o, u, t + N + 1);
    waitIdle();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t;
    int vc0;

    RST_N  = 1'b0;
    start  = 1'b0;
    scan   = 1'b0;
    ch_sel = '0;
    vsup   = 1.0;
    for (int i = 0; i < NCH; i++) vin[i] = 0.0;

    repeat (3) @(negedge CLK);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_valid", int'(valid), 0);
    checkOutput("rst_code", int'(code), 0);
    checkOutput("rst_ch_out", int'(ch_out), 0);
    checkOutput("rst_ovr", int'(ovr), 0);
    checkOutput("rst_unr", int'(unr), 0);
    RST_N = 1'b1;
    @(negedge CLK);

    // Mid-scale, exact thresholds, full scale and out-of-range inputs.
    convertOne(0, 0.3, 2, 0, 0);
    convertOne(1, 0.25, 2, 0, 0);
    convertOne(1, 0.875, 7, 0, 0);
    convertOne(1, 1.0, 7, 0, 0);
    convertOne(2, 1.2, 7, 1, 0);
    convertOne(2, -0.1, 0, 0, 1);

    // Scan from channel 1: busy must stay high until the last result cycle.
    vin[0] = 0.05; vin[1] = 0.4; vin[2] = 0.6; vin[3] = 0.95;
    applyStimulus(1, 1'b1, 1'b1, t);
    pushExp(1, 3, 0, 0, t + N + 1);
    pushExp(2, 4, 0, 0, t + N + 1 + (N + 2));
    pushExp(3, 7, 0, 0, t + N + 1 + 2 * (N + 2));
    for (int j = 1; j <= 2 * (N + 2) + N + 1; j++) begin
      @(negedge CLK);
      checkOutput("scan_busy_high", int'(busy), 1);
    end
    @(negedge CLK);
    checkOutput("scan_busy_fall", int'(busy), 0);
    waitIdle();

    // A start pulse while busy must not queue a second conversion.
    vin[0] = 0.3;
    vc0 = valid_count;
    applyStimulus(0, 1'b0, 1'b1, t);
    pushExp(0, 2, 0, 0, t + N + 1);
    @(negedge CLK);
    ch_sel = CW'(1);
    start  = 1'b1;
    @(negedge CLK);
    start  = 1'b0;
    waitIdle();
    repeat (10) @(negedge CLK);
    checkOutput("single_valid_count", valid_count - vc0, 1);

    // Out-of-range channel index is ignored entirely.
    vc0 = valid_count;
    applyStimulus(5, 1'b0, 1'b0, t);
    repeat (10) @(negedge CLK);
    checkOutput("bad_ch_busy", int'(busy), 0);
    checkOutput("bad_ch_valid_count", valid_count - vc0, 0);

    // Reset during the second CONV cycle aborts the conversion.
    vin[0] = 0.6;
    vc0 = valid_count;
    applyStimulus(0, 1'b0, 1'b1, t);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    checkOutput("midrst_busy", int'(busy), 0);
    checkOutput("midrst_code", int'(code), 0);
    RST_N = 1'b1;
    repeat (12) @(negedge CLK);
    checkOutput("midrst_valid_count", valid_count - vc0, 0);

    convertOne(3, 0.6, 4, 0, 0);

    checkOutput("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
